// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch memory handshake: request/grant on the address phase,
// rvalid/rdata on the response phase.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the multicycle core: owns PC and IR, fetches one word per
// IRWrite over the req/gnt/rvalid handshake, and faults permanently on timeout.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IRWrite,
    input  logic               PCUpdate,
    input  logic [XLEN-1:0]    pc_next,
    instr_fetch_unit_if.master m_if,
    output logic [31:0]        instr,
    output logic [6:0]         opcode,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    old_pc,
    output logic               instr_valid,
    output logic               busy,
    output logic               fetch_fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_old_pc;
    logic [XLEN-1:0] r_fetch_addr;
    logic [31:0]     r_instr;
    logic [CNT_W-1:0] r_count;
    logic            r_mem_req;
    logic            r_instr_valid;
    logic            r_busy;
    logic            r_fault;

    logic            w_rsp;
    logic            w_expired;

    // A response counts only when granted in REQ, or any rvalid while in WAIT.
    assign w_rsp = ((r_state == ST_REQ) && m_if.mem_gnt && m_if.mem_rvalid) ||
                   ((r_state == ST_WAIT) && m_if.mem_rvalid);
    assign w_expired = (r_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_old_pc      <= RESET_PC;
            r_fetch_addr  <= '0;
            r_instr       <= NOP;
            r_count       <= '0;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            // PC is independent of the fetch FSM; in-flight address lives in r_fetch_addr.
            if (PCUpdate) begin
                r_pc <= pc_next;
            end

            case (r_state)
                ST_IDLE: begin
                    if (IRWrite) begin
                        r_state      <= ST_REQ;
                        r_fetch_addr <= {r_pc[XLEN-1:2], 2'b00};
                        r_count      <= '0;
                        r_mem_req    <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (w_rsp) begin
                        r_state       <= ST_IDLE;
                        r_instr       <= m_if.mem_rdata;
                        r_old_pc      <= r_fetch_addr;
                        r_instr_valid <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_busy        <= 1'b0;
                    end else if (w_expired) begin
                        r_state   <= ST_FAULT;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_fault   <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                        if ((r_state == ST_REQ) && m_if.mem_gnt) begin
                            r_state   <= ST_WAIT;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_if.mem_req  = r_mem_req;
    assign m_if.mem_addr = r_fetch_addr;
    assign instr         = r_instr;
    assign opcode        = r_instr[6:0];
    assign pc            = r_pc;
    assign old_pc        = r_old_pc;
    assign instr_valid   = r_instr_valid;
    assign busy          = r_busy;
    assign fetch_fault   = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scenario tasks plus randomized fetches checked
// against a transaction-level model of PC/IR/timeout behaviour.
module tb_instr_fetch_unit;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IRWrite = 1'b0;
    logic        PCUpdate = 1'b0;
    logic [31:0] pc_next = '0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic        instr_valid;
    logic        busy;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    // Transaction-level model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_old_pc;

    instr_fetch_unit_if #(.XLEN(XLEN)) mif ();

    instr_fetch_unit #(
        .XLEN    (XLEN),
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .IRWrite    (IRWrite),
        .PCUpdate   (PCUpdate),
        .pc_next    (pc_next),
        .m_if       (mif),
        .instr      (instr),
        .opcode     (opcode),
        .pc         (pc),
        .old_pc     (old_pc),
        .instr_valid(instr_valid),
        .busy       (busy),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = '0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        PCUpdate = 1'b1;
        pc_next  = v;
        tick();
        PCUpdate = 1'b0;
        m_pc     = v;
    endtask

    // Memory responder: grants after gnt_dly REQ cycles, answers rv_dly cycles
    // after grant (0 = same cycle). Reports what was observed, no checking.
    task automatic run_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                             input int pcu_at, input logic [31:0] pcu_val, input bit keep_ir,
                             output int req_cyc, output int busy_cyc, output int iv_cnt,
                             output bit stable, output logic [31:0] addr0,
                             output logic [31:0] addr_end);
        int  k;
        int  w;
        bit  granted;
        bit  rsp;
        req_cyc  = 0;
        busy_cyc = 0;
        iv_cnt   = 0;
        stable   = 1'b1;
        k        = 0;
        w        = 0;
        granted  = 1'b0;
        IRWrite  = 1'b1;
        tick();
        if (!keep_ir) IRWrite = 1'b0;
        addr0 = mif.mem_addr;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (mif.mem_req === 1'b1) begin
                req_cyc++;
                if (mif.mem_addr !== addr0) stable = 1'b0;
            end
            if (instr_valid === 1'b1) iv_cnt++;
            if (busy !== 1'b1) break;
            busy_cyc++;
            PCUpdate = (cyc == pcu_at);
            pc_next  = (cyc == pcu_at) ? pcu_val : $urandom;
            rsp = 1'b0;
            if (!granted) begin
                if (k == gnt_dly) begin
                    granted        = 1'b1;
                    mif.mem_gnt    = 1'b1;
                    rsp            = (rv_dly == 0);
                    mif.mem_rvalid = rsp;
                end else begin
                    mif.mem_gnt    = 1'b0;
                    mif.mem_rvalid = 1'($urandom);
                end
                k++;
            end else begin
                w++;
                mif.mem_gnt    = 1'b0;
                rsp            = (w == rv_dly);
                mif.mem_rvalid = rsp;
            end
            mif.mem_rdata = rsp ? rdata : $urandom;
            tick();
        end
        addr_end       = mif.mem_addr;
        IRWrite        = 1'b0;
        PCUpdate       = 1'b0;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        tick();
        if (instr_valid === 1'b1) iv_cnt++;
    endtask

    task automatic test_reset;
        int rq, bc, iv;
        bit st;
        logic [31:0] a0, ae;
        repeat (2) tick();
        @(negedge clk) reset = 1'b1;
        set_pc(32'h0000_0040);
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        checks++;
        if (mif.mem_req !== 1'b1) begin
            errors++; $display("FAIL pre_reset_req: got %b want 1", mif.mem_req);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (mif.mem_req !== 1'b0 || busy !== 1'b0 || fetch_fault !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b busy=%b fault=%b iv=%b want all 0",
                     mif.mem_req, busy, fetch_fault, instr_valid);
        end
        checks++;
        if (pc !== 32'h0 || old_pc !== 32'h0 || mif.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got pc=%h old_pc=%h addr=%h want 0", pc, old_pc, mif.mem_addr);
        end
        checks++;
        if (instr !== NOP || opcode !== 7'b0010011) begin
            errors++; $display("FAIL reset_instr: got %h/%b want %h/0010011", instr, opcode, NOP);
        end
        m_pc = 32'h0; m_instr = NOP; m_old_pc = 32'h0;
        @(negedge clk) reset = 1'b1;
        // Late response after reset release must be ignored in IDLE
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        mif.mem_rvalid = 1'b0;
        checks++;
        if (instr !== NOP || instr_valid !== 1'b0) begin
            errors++; $display("FAIL late_rvalid: got instr=%h iv=%b want %h iv=0", instr, instr_valid, NOP);
        end
        run_fetch(0, 1, 32'h00A0_0093, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        m_instr = 32'h00A0_0093; m_old_pc = 32'h0;
        checks++;
        if (instr !== 32'h00A0_0093 || opcode !== 7'b0010011) begin
            errors++; $display("FAIL first_fetch_instr: got %h/%b want 00a00093/0010011", instr, opcode);
        end
        checks++;
        if (old_pc !== 32'h0 || a0 !== 32'h0) begin
            errors++; $display("FAIL first_fetch_addr: got old_pc=%h addr=%h want 0", old_pc, a0);
        end
        checks++;
        if (iv !== 1 || bc !== 2 || rq !== 1) begin
            errors++; $display("FAIL first_fetch_timing: got iv=%0d busy=%0d req=%0d want 1/2/1", iv, bc, rq);
        end
    endtask

    task automatic test_gnt_delay;
        int rq, bc, iv;
        bit st;
        logic [31:0] a0, ae;
        set_pc(32'h0000_0004);
        checks++;
        if (pc !== 32'h4) begin
            errors++; $display("FAIL pc_load: got %h want 00000004", pc);
        end
        run_fetch(3, 1, 32'h0020_81B3, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        m_instr = 32'h0020_81B3; m_old_pc = 32'h4;
        checks++;
        if (rq !== 4 || st !== 1'b1 || a0 !== 32'h4) begin
            errors++; $display("FAIL gnt_delay_req: got req=%0d stable=%b addr=%h want 4/1/00000004", rq, st, a0);
        end
        checks++;
        if (bc !== 5 || iv !== 1) begin
            errors++; $display("FAIL gnt_delay_busy: got busy=%0d iv=%0d want 5/1", bc, iv);
        end
        checks++;
        if (opcode !== 7'b0110011 || instr !== 32'h0020_81B3 || old_pc !== 32'h4) begin
            errors++; $display("FAIL gnt_delay_instr: got %h op=%b old_pc=%h", instr, opcode, old_pc);
        end
    endtask

    task automatic test_same_cycle;
        int rq, bc, iv;
        bit st;
        logic [31:0] a0, ae;
        run_fetch(0, 0, 32'h0000_006F, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        m_instr = 32'h0000_006F; m_old_pc = m_pc;
        checks++;
        if (bc !== 1 || rq !== 1 || iv !== 1) begin
            errors++; $display("FAIL same_cycle_timing: got busy=%0d req=%0d iv=%0d want 1/1/1", bc, rq, iv);
        end
        checks++;
        if (opcode !== 7'b1101111 || busy !== 1'b0) begin
            errors++; $display("FAIL same_cycle_op: got op=%b busy=%b want 1101111/0", opcode, busy);
        end
    endtask

    task automatic test_pc_update;
        int rq, bc, iv;
        bit st;
        logic [31:0] a0, ae;
        logic [31:0] d;
        set_pc(32'h0000_0008);
        d = $urandom;
        run_fetch(0, 2, d, 1, 32'h0000_0100, 1'b0, rq, bc, iv, st, a0, ae);
        m_pc = 32'h100; m_instr = d; m_old_pc = 32'h8;
        checks++;
        if (a0 !== 32'h8 || ae !== 32'h8) begin
            errors++; $display("FAIL midfetch_addr: got start=%h end=%h want 00000008", a0, ae);
        end
        checks++;
        if (old_pc !== 32'h8 || pc !== 32'h100 || instr !== d) begin
            errors++; $display("FAIL midfetch_pc: got old_pc=%h pc=%h instr=%h want 8/100/%h", old_pc, pc, instr, d);
        end
        run_fetch(0, 1, $urandom, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        checks++;
        if (a0 !== 32'h100) begin
            errors++; $display("FAIL next_fetch_addr: got %h want 00000100", a0);
        end
        set_pc(32'h0000_0102);
        d = $urandom;
        run_fetch(1, 1, d, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        m_instr = d; m_old_pc = 32'h100;
        checks++;
        if (pc !== 32'h102 || a0 !== 32'h100 || old_pc !== 32'h100) begin
            errors++; $display("FAIL unaligned_pc: got pc=%h addr=%h old_pc=%h want 102/100/100", pc, a0, old_pc);
        end
    endtask

    task automatic test_back_to_back;
        int rq, bc, iv;
        bit st;
        logic [31:0] a0, ae;
        logic [31:0] d;
        for (int n = 0; n < 2; n++) begin
            d = $urandom;
            run_fetch(2, 2, d, -1, 32'h0, 1'b1, rq, bc, iv, st, a0, ae);
            m_instr = d; m_old_pc = {m_pc[31:2], 2'b00};
            checks++;
            if (rq !== 3 || bc !== 5 || iv !== 1 || instr !== d) begin
                errors++;
                $display("FAIL held_irwrite[%0d]: got req=%0d busy=%0d iv=%0d instr=%h want 3/5/1/%h",
                         n, rq, bc, iv, instr, d);
            end
        end
        iv = 0;
        mif.mem_rvalid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            mif.mem_rdata = ~m_instr;
            tick();
            if (instr_valid === 1'b1 || busy === 1'b1) iv++;
        end
        mif.mem_rvalid = 1'b0;
        checks++;
        if (instr !== m_instr || iv !== 0) begin
            errors++; $display("FAIL spurious_rvalid: got instr=%h events=%0d want %h/0", instr, iv, m_instr);
        end
    endtask

    task automatic test_random;
        int rq, bc, iv;
        bit st;
        logic [31:0] a0, ae;
        for (int n = 0; n < 25; n++) begin
            int          g;
            int          r;
            int          tot;
            int          pa;
            logic [31:0] d;
            logic [31:0] pv;
            logic [31:0] exp_addr;
            g   = int'($urandom_range(0, 4));
            r   = int'($urandom_range(0, 4));
            tot = g + 1 + r;
            d   = $urandom;
            pv  = $urandom;
            pa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, tot - 1)) : -1;
            if ($urandom_range(0, 2) == 0) set_pc($urandom);
            exp_addr = {m_pc[31:2], 2'b00};
            run_fetch(g, r, d, pa, pv, 1'($urandom), rq, bc, iv, st, a0, ae);
            if (pa >= 0) m_pc = pv;
            m_instr  = d;
            m_old_pc = exp_addr;
            checks++;
            if (a0 !== exp_addr || st !== 1'b1 || rq !== g + 1) begin
                errors++;
                $display("FAIL rand_req[%0d]: got addr=%h stable=%b req=%0d want %h/1/%0d",
                         n, a0, st, rq, exp_addr, g + 1);
            end
            checks++;
            if (instr !== m_instr || old_pc !== m_old_pc || pc !== m_pc) begin
                errors++;
                $display("FAIL rand_state[%0d]: got instr=%h old_pc=%h pc=%h want %h/%h/%h",
                         n, instr, old_pc, pc, m_instr, m_old_pc, m_pc);
            end
            checks++;
            if (bc !== tot || iv !== 1) begin
                errors++; $display("FAIL rand_timing[%0d]: got busy=%0d iv=%0d want %0d/1", n, bc, iv, tot);
            end
        end
    endtask

    task automatic test_timeout;
        int rq, bc, iv;
        int reqs;
        bit st;
        logic [31:0] a0, ae;
        logic [31:0] d;
        run_fetch(0, 1000, $urandom, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        checks++;
        if (fetch_fault !== 1'b1 || busy !== 1'b0 || mif.mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_flags: got fault=%b busy=%b req=%b want 1/0/0", fetch_fault, busy, mif.mem_req);
        end
        checks++;
        if (bc !== TIMEOUT || rq !== 1 || iv !== 0) begin
            errors++; $display("FAIL timeout_len: got busy=%0d req=%0d iv=%0d want %0d/1/0", bc, rq, iv, TIMEOUT);
        end
        checks++;
        if (instr !== m_instr || old_pc !== m_old_pc) begin
            errors++; $display("FAIL timeout_instr: got %h/%h want %h/%h", instr, old_pc, m_instr, m_old_pc);
        end
        reqs = 0;
        IRWrite = 1'b1;
        repeat (4) begin
            tick();
            if (mif.mem_req === 1'b1 || busy === 1'b1) reqs++;
        end
        IRWrite = 1'b0;
        checks++;
        if (reqs !== 0 || fetch_fault !== 1'b1) begin
            errors++; $display("FAIL fault_terminal: got reqs=%0d fault=%b want 0/1", reqs, fetch_fault);
        end
        set_pc(32'h0000_0200);
        checks++;
        if (pc !== 32'h200) begin
            errors++; $display("FAIL fault_pc_update: got %h want 00000200", pc);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (fetch_fault !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL fault_reset: got fault=%b pc=%h want 0/0", fetch_fault, pc);
        end
        @(negedge clk) reset = 1'b1;
        m_pc = 32'h0; m_instr = NOP; m_old_pc = 32'h0;
        run_fetch(1000, 0, $urandom, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        checks++;
        if (rq !== TIMEOUT || fetch_fault !== 1'b1 || st !== 1'b1 || instr !== NOP) begin
            errors++;
            $display("FAIL no_gnt_timeout: got req=%0d fault=%b stable=%b instr=%h want %0d/1/1/%h",
                     rq, fetch_fault, st, instr, TIMEOUT, NOP);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        d = $urandom;
        run_fetch(0, 1, d, -1, 32'h0, 1'b0, rq, bc, iv, st, a0, ae);
        checks++;
        if (instr !== d || iv !== 1 || fetch_fault !== 1'b0) begin
            errors++; $display("FAIL post_fault_fetch: got instr=%h iv=%0d fault=%b want %h/1/0", instr, iv, fetch_fault, d);
        end
    endtask

    initial begin
        test_reset();
        test_gnt_delay();
        test_same_cycle();
        test_pc_update();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the multicycle control FSM.
- Owns the PC and the instruction register (IR), and fetches each instruction word over a request/grant/response memory handshake.
- Presents opcode = IR[6:0] to the control FSM, plus old_pc for PC-relative datapath ops.
- Raises busy so the FSM can hold in FETCH until the word arrives.

Parameters:
XLEN, 32, width of PC and address bus
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT, 16, max cycles in REQ+WAIT before a fetch fault (must be >= 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
IRWrite  in  1  from control FSM; starts a fetch when sampled high in IDLE
PCUpdate  in  1  from control FSM; load pc_next into pc
pc_next  in  XLEN  next PC from ALU/result mux
mem_req  out  1  fetch request valid
mem_addr  out  XLEN  word-aligned fetch address
mem_gnt  in  1  memory accepted the request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
instr  out  32  instruction register
opcode  out  7  instr[6:0], combinational
pc  out  XLEN  current PC
old_pc  out  XLEN  PC of the instruction held in instr
instr_valid  out  1  one-cycle pulse after a new instr is latched
busy  out  1  fetch in progress
fetch_fault  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; pc=old_pc=RESET_PC; instr=32'h0000_0013 (NOP), so opcode=7'b0010011.
  - mem_req=0, mem_addr=0, instr_valid=0, busy=0, fetch_fault=0, timeout count=0.
  - Reset mid-fetch drops mem_req immediately; any late mem_rvalid after reset release is ignored in IDLE.
- States: IDLE, REQ, WAIT, FAULT.
- IDLE:
  - IRWrite=1 -> REQ. On that edge, fetch_addr <= {pc[XLEN-1:2],2'b00} and count <= 0.
  - IRWrite=0 -> stay in IDLE.
- REQ:
  - mem_req=1 and mem_addr=fetch_addr, both held stable until mem_gnt=1.
  - mem_gnt=1 and mem_rvalid=0 -> WAIT.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle -> latch immediately, -> IDLE.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1 -> latch, -> IDLE.
- Latch (on the edge where the response is sampled):
  - instr <= mem_rdata; old_pc <= fetch_addr.
  - instr_valid=1 for exactly the next cycle.
- busy=1 in REQ and WAIT, 0 otherwise.
- Timeout:
  - count increments every cycle in REQ/WAIT.
  - If count reaches TIMEOUT-1 with no response -> FAULT.
  - Entering FAULT: mem_req=0, fetch_fault=1, instr unchanged.
  - FAULT is terminal until reset; IRWrite is ignored and busy=0.
- IRWrite while busy is ignored; no queueing.
- PC update:
  - PCUpdate=1 loads pc <= pc_next on any state, including mid-fetch.
  - A mid-fetch update does not disturb the in-flight mem_addr (fetch_addr is separate).
  - pc_next[1:0] are stored as given; only mem_addr is forced word-aligned.
- mem_rvalid while in IDLE or REQ without mem_gnt is ignored.
- Fetch latency with mem_gnt in the first REQ cycle and mem_rvalid one cycle later: IRWrite sampled at edge E0, mem_req high in cycle E0..E1, instr updated at E2, instr_valid high E2..E3.

Test Plan:
- Reset with reset=0 mid-cycle -> pc=0, instr=32'h00000013, opcode=7'b0010011, mem_req=0 asynchronously; release reset, then IRWrite=1 with gnt in cycle 1 and rvalid=1, rdata=32'h00A00093 in cycle 2 -> instr=32'h00A00093, opcode=7'b0010011, old_pc=0, single instr_valid pulse.
- Memory delays gnt by 3 cycles -> mem_req and mem_addr=0x4 stay stable for all 4 REQ cycles and busy=1 throughout; then rvalid with rdata=32'h002081B3 -> opcode=7'b0110011.
- Same-cycle gnt+rvalid with rdata=32'h0000006F -> return to IDLE next cycle, opcode=7'b1101111, total busy=1 cycle.
- PCUpdate=1, pc_next=0x100 during WAIT of the fetch at 0x8 -> mem_addr unchanged, old_pc=0x8 after latch, pc=0x100; next fetch issues mem_addr=0x100; pc_next=0x102 -> mem_addr=0x100.
- Grant but no rvalid for TIMEOUT cycles -> fetch_fault=1, busy=0, instr holds its previous value; further IRWrite produces no mem_req until reset.
- IRWrite held high through a fetch, and a spurious rvalid while IDLE -> exactly one request per IDLE->REQ entry; the spurious rvalid does not change instr.
